// File: rtl/uart_tx_core.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one or two stop bits.
// Each frame bit is held for one tick period and the serial line is registered.
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  par_en,
    input  logic                  par_odd,
    input  logic                  stop2,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int            IW       = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP2ND  = IW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  accept;
    logic                  last_stop;

    assign last_stop = !stop2_q || (idx_q == STOP2ND);
    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_STOP) && tick && last_stop);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != S_IDLE);
    assign tx_out    = tx_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;

        // Acceptance only happens in IDLE or on the final stop tick, so the
        // frame register can be loaded here independently of the state branch.
        if (accept) begin
            shift_d   = in_data;
            par_en_d  = par_en;
            par_bit_d = (^in_data) ^ par_odd;
            stop2_d   = stop2;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (tick) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        idx_d = '0;
                        if (accept) begin
                            state_d = S_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = STOP2ND;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core (8-bit and 5-bit instances) against a
// per-tick-period line model built from the frame rules.
module tb_uart_tx_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic       stop2 = 1'b0;
    logic [7:0] in_data8 = '0;
    logic       in_valid8 = 1'b0;
    logic [4:0] in_data5 = '0;
    logic       in_valid5 = 1'b0;
    logic       rdy8, tx8, busy8;
    logic       rdy5, tx5, busy5;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];
    logic s8l, s8b, s5l, s5b;
    int unsigned acc8 = 0;
    int unsigned rb8 = 0;

    uart_tx_core #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .tick(tick), .in_data(in_data8), .in_valid(in_valid8),
        .in_ready(rdy8), .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
        .tx_out(tx8), .busy(busy8)
    );

    uart_tx_core #(.DATA_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .tick(tick), .in_data(in_data5), .in_valid(in_valid5),
        .in_ready(rdy5), .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
        .tx_out(tx5), .busy(busy5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid8 && rdy8) acc8 <= acc8 + 1;
        if (rdy8 && busy8)     rb8  <= rb8 + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line value for each tick period of one frame.
    function automatic void add_frame(input int w, input int unsigned d,
                                      input bit pe, input bit po, input bit s2);
        int unsigned m;
        m = d & ((32'd1 << w) - 1);
        exp_q.push_back(1'b0);
        for (int i = 0; i < w; i++) exp_q.push_back(bit'((m >> i) & 1));
        if (pe) exp_q.push_back(bit'(($countones(m) + int'(po)) % 2));
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endfunction

    // One tick period: sample both lines mid-period, then a one-cycle tick.
    task automatic period();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 7) begin
                s8l = tx8; s8b = busy8; s5l = tx5; s5b = busy5;
            end
        end
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic run(input int sel, input int n, input string tag);
        bit e;
        for (int k = 0; k < n; k++) begin
            period();
            e = exp_q.pop_front();
            if (sel == 0) begin
                chk($sformatf("%s_line%0d", tag, k), {7'd0, s8l}, {7'd0, e});
                chk($sformatf("%s_busy%0d", tag, k), {7'd0, s8b}, 8'd1);
            end else begin
                chk($sformatf("%s_line%0d", tag, k), {7'd0, s5l}, {7'd0, e});
                chk($sformatf("%s_busy%0d", tag, k), {7'd0, s5b}, 8'd1);
            end
        end
    endtask

    task automatic send(input int sel, input int unsigned d, input bit pe, input bit po,
                        input bit s2, input bit tick_acc, input string tag);
        @(negedge clk);
        par_en = pe; par_odd = po; stop2 = s2; tick = tick_acc;
        if (sel == 0) begin in_data8 = d[7:0]; in_valid8 = 1'b1; end
        else begin in_data5 = d[4:0]; in_valid5 = 1'b1; end
        #1;
        chk({tag, "_rdy_idle"}, {7'd0, (sel == 0) ? rdy8 : rdy5}, 8'd1);
        @(negedge clk);
        in_valid8 = 1'b0; in_valid5 = 1'b0; tick = 1'b0;
        chk({tag, "_busy_acc"}, {7'd0, (sel == 0) ? busy8 : busy5}, 8'd1);
        chk({tag, "_line_armed"}, {7'd0, (sel == 0) ? tx8 : tx5}, 8'd1);
        exp_q.delete();
        exp_q.push_back(1'b1);
        add_frame((sel == 0) ? 8 : 5, d, pe, po, s2);
    endtask

    task automatic idle_chk(input int sel, input string tag);
        @(negedge clk);
        chk({tag, "_idle_line"}, {7'd0, (sel == 0) ? tx8 : tx5}, 8'd1);
        chk({tag, "_idle_busy"}, {7'd0, (sel == 0) ? busy8 : busy5}, 8'd0);
        chk({tag, "_idle_rdy"}, {7'd0, (sel == 0) ? rdy8 : rdy5}, 8'd1);
    endtask

    initial begin
        int unsigned a0, r0, d;
        bit pe, po, s2, ta;

        #2 rst = 1'b0;
        #1;
        chk("rst_line", {7'd0, tx8}, 8'd1);
        chk("rst_busy", {7'd0, busy8}, 8'd0);
        chk("rst_rdy", {7'd0, rdy8}, 8'd1);
        chk("rst_line5", {7'd0, tx5}, 8'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Tick while idle must not start anything.
        period();
        chk("idle_tick", {6'd0, s8l, s8b}, 8'b10);

        send(0, 32'hA5, 0, 0, 0, 0, "a5");
        run(0, exp_q.size(), "a5");
        idle_chk(0, "a5");

        send(0, 32'hA5, 1, 0, 0, 1, "a5pe");
        run(0, exp_q.size(), "a5pe");
        idle_chk(0, "a5pe");

        send(0, 32'hA5, 1, 1, 0, 0, "a5po");
        run(0, exp_q.size(), "a5po");
        idle_chk(0, "a5po");

        send(0, 32'hA5, 1, 0, 1, 0, "a5s2");
        chk("a5s2_len", 8'(exp_q.size()), 8'd13);
        run(0, exp_q.size(), "a5s2");
        idle_chk(0, "a5s2");

        // Back-to-back: 0x01 accepted from idle, 0xFF taken on the last stop tick.
        a0 = acc8; r0 = rb8;
        @(negedge clk);
        par_en = 0; par_odd = 0; stop2 = 0;
        in_data8 = 8'h01; in_valid8 = 1'b1;
        @(negedge clk);
        in_data8 = 8'hFF;
        exp_q.delete();
        exp_q.push_back(1'b1);
        add_frame(8, 32'h01, 0, 0, 0);
        add_frame(8, 32'hFF, 0, 0, 0);
        run(0, 11, "b2b_f1");
        in_valid8 = 1'b0;
        run(0, exp_q.size(), "b2b_f2");
        idle_chk(0, "b2b");
        chk("b2b_accepts", 8'(acc8 - a0), 8'd2);
        chk("b2b_rdy_pulses", 8'(rb8 - r0), 8'd2);

        // Inputs change mid-frame and a stray in_valid pulse while not ready.
        send(0, 32'h3C, 1, 0, 0, 0, "mid");
        run(0, 4, "mid_a");
        a0 = acc8;
        in_data8 = 8'hC3; par_en = 0; par_odd = 1; stop2 = 1;
        @(negedge clk); in_valid8 = 1'b1;
        @(negedge clk);
        @(negedge clk); in_valid8 = 1'b0;
        run(0, exp_q.size(), "mid_b");
        idle_chk(0, "mid");
        chk("mid_no_accept", 8'(acc8 - a0), 8'd0);

        for (int f = 0; f < 10; f++) begin
            d = $urandom_range(0, 255);
            pe = 1'($urandom); po = 1'($urandom); s2 = 1'($urandom); ta = 1'($urandom);
            send(0, d, pe, po, s2, ta, $sformatf("rnd%0d", f));
            run(0, exp_q.size(), $sformatf("rnd%0d", f));
            idle_chk(0, $sformatf("rnd%0d", f));
        end

        send(1, 32'h13, 1, 1, 0, 0, "w5");
        chk("w5_len", 8'(exp_q.size()), 8'd9);
        run(1, exp_q.size(), "w5");
        idle_chk(1, "w5");

        // Reset asserted between clock edges during data bit 3.
        send(0, 32'hA5, 0, 0, 0, 0, "rst");
        run(0, 5, "rst_pre");
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_line", {7'd0, tx8}, 8'd1);
        chk("rstmid_busy", {7'd0, busy8}, 8'd0);
        chk("rstmid_rdy", {7'd0, rdy8}, 8'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int p = 0; p < 20; p++) begin
            period();
            chk($sformatf("post_rst%0d", p), {6'd0, s8l, s8b}, 8'b10);
        end
        send(0, 32'h5A, 1, 1, 1, 0, "fresh");
        run(0, exp_q.size(), "fresh");
        idle_chk(0, "fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
